// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Central stall/flush sequencer for the 5-stage pipeline. It merges the
// load-use stall request, the branch-taken flush and the data-memory
// request/acknowledge handshake into one consistent set of per-stage controls.
// It also owns a wait-timeout watchdog and a stall-cycle performance counter.
//
// Parameters
//   TIMEOUT  maximum WAIT cycles without dmem_ack_i before the error trap (1..255)
//   CNT_W    width of the stall-cycle counter
//
// Ports
//   clk_i              in   clock, rising edge
//   rst_i              in   asynchronous active-high reset
//   hazard_stall_i     in   load-use stall request from hazard detection
//   branch_taken_i     in   branch resolved taken in ID
//   ex_mem_memread_i   in   MEM-stage instruction is a load
//   ex_mem_memwrite_i  in   MEM-stage instruction is a store
//   dmem_ack_i         in   data memory done (single-cycle pulse)
//   dmem_req_o         out  data memory request (registered)
//   pc_write_o         out  PC update enable
//   if_id_write_o      out  IF/ID load enable
//   if_id_flush_o      out  IF/ID clear to NOP
//   id_ex_bubble_o     out  insert NOP into ID/EX
//   ex_mem_write_o     out  EX/MEM load enable
//   mem_wb_bubble_o    out  insert NOP into MEM/WB
//   timeout_err_o      out  sticky memory-timeout error
//   stall_cnt_o        out  saturating count of cycles with pc_write_o=0
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hazard_stall_i,
    input  logic             branch_taken_i,
    input  logic             ex_mem_memread_i,
    input  logic             ex_mem_memwrite_i,
    input  logic             dmem_ack_i,
    output logic             dmem_req_o,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_bubble_o,
    output logic             timeout_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Last legal wait-counter value before the watchdog trips.
    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_wait_cnt;
    logic             r_req;
    logic             r_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_mem_op;
    logic             w_freeze;

    assign w_mem_op = ex_mem_memread_i | ex_mem_memwrite_i;

    // The freeze also covers the IDLE cycle in which the memory op is first
    // seen: the request is registered, so the pipeline must already hold while
    // the request goes out on the next edge.
    assign w_freeze = ((r_state == ST_IDLE) && w_mem_op) ||
                      (r_state == ST_WAIT) ||
                      (r_state == ST_ERR);

    // -------------------------------------------------------------------------
    // Memory handshake FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_op) begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_ack_i) begin
                    w_next = ST_DONE;
                end else if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_next = ST_ERR;
                end
            end
            // DONE lets the completed op leave MEM before mem_op is looked at
            // again, so the same access is never requested twice.
            ST_DONE: w_next = ST_IDLE;
            ST_ERR:  w_next = ST_ERR;
            default: w_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Memory handshake FSM: state, wait counter, request and error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 8'd0;
            r_req      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            // Counter only advances while staying in WAIT; any other path
            // leaves it at zero so it is already clear on WAIT entry.
            if ((r_state == ST_WAIT) && (w_next == ST_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= 8'd0;
            end
            // Request is a flop that mirrors "state is WAIT" exactly.
            r_req <= (w_next == ST_WAIT);
            r_err <= r_err | (w_next == ST_ERR);
        end
    end

    // -------------------------------------------------------------------------
    // Per-stage controls: memory freeze > load-use stall > branch flush
    // -------------------------------------------------------------------------
    always_comb begin
        pc_write_o      = 1'b1;
        if_id_write_o   = 1'b1;
        ex_mem_write_o  = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        mem_wb_bubble_o = 1'b0;
        if (!rst_i) begin
            if (w_freeze) begin
                // Everything upstream of MEM holds, so pending stall/branch
                // requests stay valid and are acted on after the freeze.
                pc_write_o      = 1'b0;
                if_id_write_o   = 1'b0;
                ex_mem_write_o  = 1'b0;
                mem_wb_bubble_o = 1'b1;
            end else if (hazard_stall_i) begin
                // Branch flush is suppressed: the branch in ID is held too.
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
            end else if (branch_taken_i) begin
                if_id_flush_o = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stall-cycle performance counter (saturating)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (!pc_write_o && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign dmem_req_o    = r_req;
    assign timeout_err_o = r_err;
    assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Merges the ID-stage load-use stall request, the ID-stage branch-taken flush and a variable-latency data-memory handshake into one consistent set of per-stage write-enable, bubble and flush controls. Owns the MEM-stage request/acknowledge FSM, a wait-timeout watchdog and a stall-cycle performance counter. Sits beside the hazard detection unit and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
TIMEOUT, 255, maximum WAIT cycles without dmem_ack_i before the error trap; legal range 1..255.
CNT_W, 32, width of the stall-cycle counter.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
hazard_stall_i  in  1  load-use stall request from hazard detection
branch_taken_i  in  1  branch resolved taken in ID
ex_mem_memread_i  in  1  MEM-stage instruction is a load
ex_mem_memwrite_i  in  1  MEM-stage instruction is a store
dmem_ack_i  in  1  data memory done; single-cycle pulse
dmem_req_o  out  1  data memory request, registered
pc_write_o  out  1  PC update enable
if_id_write_o  out  1  IF/ID load enable
if_id_flush_o  out  1  IF/ID clear to NOP
id_ex_bubble_o  out  1  insert NOP into ID/EX
ex_mem_write_o  out  1  EX/MEM load enable
mem_wb_bubble_o  out  1  insert NOP into MEM/WB
timeout_err_o  out  1  sticky memory-timeout error
stall_cnt_o  out  CNT_W  count of cycles with pc_write_o=0

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is asynchronous and active-high.
- Reset: state=IDLE, wait counter=0, dmem_req_o=0, timeout_err_o=0, stall_cnt_o=0.
- While rst_i=1, outputs are forced to defaults: pc_write_o=1, if_id_write_o=1, ex_mem_write_o=1, if_id_flush_o=0, id_ex_bubble_o=0, mem_wb_bubble_o=0.
- Reset in any state, including mid-WAIT or ERR, returns to IDLE immediately. No request is reissued.
- mem_op = ex_mem_memread_i OR ex_mem_memwrite_i.
- FSM states: IDLE, WAIT, DONE, ERR.
  - IDLE: mem_op=1 -> WAIT; otherwise stay.
  - WAIT: dmem_ack_i=1 -> DONE. Else wait counter = TIMEOUT-1 -> ERR. Else counter+1.
  - DONE: -> IDLE unconditionally. This state prevents re-requesting the completed op.
  - ERR: terminal until reset.
- dmem_req_o=1 exactly while state=WAIT. Request latency: 1 cycle after mem_op is seen in IDLE.
- The wait counter clears on WAIT entry.
- dmem_ack_i outside WAIT is ignored.
- freeze = (IDLE AND mem_op) OR WAIT OR ERR.
- freeze=1: pc_write_o=0, if_id_write_o=0, ex_mem_write_o=0, mem_wb_bubble_o=1, id_ex_bubble_o=0, if_id_flush_o=0. All upstream stages hold. hazard_stall_i and branch_taken_i are deferred; they remain valid because stages are held.
- DONE: freeze=0, so the pipeline advances this cycle and mem_wb_bubble_o=0.
- freeze=0 AND hazard_stall_i=1: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, if_id_flush_o=0 (branch suppressed), ex_mem_write_o=1.
- freeze=0, hazard_stall_i=0, branch_taken_i=1: if_id_flush_o=1; all write enables=1.
- No request active: all write enables=1, bubbles/flush=0.
- Priority: memory freeze > load-use stall > branch flush.
- timeout_err_o is set on entry to ERR and is sticky until reset.
- stall_cnt_o increments on each rising edge where pc_write_o=0 (rst_i low). It saturates at all-ones.

Test Plan:
- Plain flow: all requests 0 for 10 cycles -> write enables=1, dmem_req_o=0, stall_cnt_o=0.
- Load with ack latency 3: memread=1 at cycle 0 -> dmem_req_o=1 for cycles 1..3; ack at cycle 3; state DONE at cycle 4 with writes enabled, IDLE at cycle 5. pc_write_o=0 for cycles 0..3; stall_cnt_o=4.
- Load-use and branch together, no mem op: hazard_stall_i=1, branch_taken_i=1 -> id_ex_bubble_o=1, pc_write_o=0, if_id_flush_o=0. Drop hazard -> if_id_flush_o=1 for one cycle.
- Branch during memory wait: branch_taken_i=1 held across WAIT -> if_id_flush_o=0 until DONE; =1 in the DONE cycle.
- Timeout with TIMEOUT=4 and no ack -> ERR after 4 WAIT cycles; timeout_err_o=1, dmem_req_o=0, pc_write_o stays 0. A late ack is ignored.
- Async reset mid-WAIT: pulse rst_i between edges -> dmem_req_o=0 immediately, stall_cnt_o=0, defaults driven. With mem_op=1 after release, a new WAIT starts one cycle later.
